// File: rtl/rv_decode_pkg.sv
// Shared RV32I/RV64I decode vocabulary: opcodes, funct fields, format codes and ALU ops.
// The ALU and the branch predictor import the same definitions.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        alu_op_e    alu_op;
        fmt_e       fmt;
        logic       rd_we;
        logic       illegal;
    } dec_t;

    // alt is funct7[5]; SUB only exists in the register-register form
    function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt,
                                               input logic allow_sub);
        case (f3)
            F3_ADD_SUB: return (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            F3_SLL:     return ALU_SLL;
            F3_SLT:     return ALU_SLT;
            F3_SLTU:    return ALU_SLTU;
            F3_XOR:     return ALU_XOR;
            F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
            F3_OR:      return ALU_OR;
            default:    return ALU_AND;
        endcase
    endfunction

    function automatic logic load_f3_ok(input logic [2:0] f3, input logic rv64);
        case (f3)
            3'd0, 3'd1, 3'd2, 3'd4, 3'd5: return 1'b1;
            3'd3, 3'd6:                   return rv64;
            default:                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_imm_gen.sv
// Combinational immediate extraction for every base format, sign-extended to XLEN.
// Also instantiated by the branch predictor.
module instr_imm_gen
    import rv_decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      fmt,
    input  logic [31:7]     instr,
    output logic [XLEN-1:0] imm
);

    logic [31:0] raw;

    always_comb begin
        raw = '0;
        case (fmt)
            FMT_I:   raw = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   raw = {instr[31:12], 12'b0};
            FMT_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: raw = '0;
        endcase
        imm = XLEN'($signed(raw));
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered RV32I/RV64I decode stage with a main/skid register pair behind a
// registered in_ready, so fetch sees full throughput without a combinational ready path.
module instr_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [3:0]      out_alu_op,
    output logic [2:0]      out_fmt,
    output logic            out_rd_we,
    output logic            out_illegal
);

    localparam logic RV64 = (XLEN == 64);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    dec_t            dec_c;
    logic [XLEN-1:0] imm_raw;
    logic [XLEN-1:0] imm_c;

    dec_t            main_q, main_d, skid_q, skid_d;
    logic [XLEN-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    logic [XLEN-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic            main_valid_q, main_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_ready_q;
    logic            in_fire;
    logic            out_fire;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    always_comb begin
        dec_c.rd      = in_instr[11:7];
        dec_c.rs1     = in_instr[19:15];
        dec_c.rs2     = in_instr[24:20];
        dec_c.alu_op  = ALU_ADD;
        dec_c.fmt     = FMT_R;
        dec_c.rd_we   = 1'b0;
        dec_c.illegal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: dec_c.fmt = FMT_U;
            OPC_JAL:            dec_c.fmt = FMT_J;
            OPC_JALR:           dec_c.fmt = FMT_I;
            OPC_BRANCH: begin
                dec_c.fmt     = FMT_B;
                dec_c.alu_op  = ALU_SUB;
                dec_c.illegal = (funct3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                dec_c.fmt     = FMT_I;
                dec_c.illegal = !load_f3_ok(funct3, RV64);
            end
            OPC_STORE: begin
                dec_c.fmt     = FMT_S;
                dec_c.illegal = RV64 ? (funct3 > 3'd3) : (funct3 > 3'd2);
            end
            OPC_OP_IMM: begin
                dec_c.fmt    = FMT_I;
                dec_c.alu_op = alu_op_from_f3(funct3, in_instr[30], 1'b0);
                // RV64 shamt is 6 bits, so bit 25 joins the shift amount
                if (funct3 == F3_SLL)
                    dec_c.illegal = (|in_instr[31:26]) | (!RV64 & in_instr[25]);
                else if (funct3 == F3_SRL_SRA)
                    dec_c.illegal = in_instr[31] | (|in_instr[29:26]) | (!RV64 & in_instr[25]);
            end
            OPC_OP: begin
                dec_c.fmt     = FMT_R;
                dec_c.alu_op  = alu_op_from_f3(funct3, funct7[5], 1'b1);
                dec_c.illegal = !((funct7 == F7_BASE) ||
                                  (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)));
            end
            default: dec_c.illegal = 1'b1;
        endcase
        // Illegal words of any kind collapse to a harmless ADD with no writeback and zero imm
        if (dec_c.illegal)
            dec_c.alu_op = ALU_ADD;
        else
            dec_c.rd_we = (dec_c.fmt != FMT_S) && (dec_c.fmt != FMT_B) && (dec_c.rd != 5'd0);
    end

    instr_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .fmt   (dec_c.fmt),
        .instr (in_instr[31:7]),
        .imm   (imm_raw)
    );

    assign imm_c = dec_c.illegal ? '0 : imm_raw;

    assign in_fire  = in_valid && in_ready_q && !flush;
    assign out_fire = main_valid_q && out_ready;

    // in_ready mirrors "skid empty", so the skid never receives while it is occupied
    always_comb begin
        main_d       = main_q;
        main_imm_d   = main_imm_q;
        main_pc_d    = main_pc_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_imm_d   = skid_imm_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_imm_d   = skid_imm_q;
                main_pc_d    = skid_pc_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_d       = dec_c;
                main_imm_d   = imm_c;
                main_pc_d    = in_pc;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = dec_c;
            skid_imm_d   = imm_c;
            skid_pc_d    = in_pc;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            main_imm_q   <= '0;
            main_pc_q    <= '0;
            main_valid_q <= 1'b0;
            skid_q       <= '0;
            skid_imm_q   <= '0;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else if (flush) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            main_imm_q   <= main_imm_d;
            main_pc_q    <= main_pc_d;
            main_valid_q <= main_valid_d;
            skid_q       <= skid_d;
            skid_imm_q   <= skid_imm_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign out_pc      = main_pc_q;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_imm     = main_imm_q;
    assign out_alu_op  = main_q.alu_op;
    assign out_fmt     = main_q.fmt;
    assign out_rd_we   = main_q.rd_we;
    assign out_illegal = main_q.illegal;

endmodule
